lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Load/store unit that acts as the initiator side of the word-addressed data memory.
- Accepts byte-addressed load and store requests from the execute stage, covering RV32I LB/LH/LW/LBU/LHU/SB/SH/SW.
- Issues word-granular reads and writes to the data memory. Sub-word stores are done as read-modify-write.
- Returns sign- or zero-extended load data and an error flag for misaligned or out-of-range accesses.

Parameters:
- DEPTH, 1024, number of 32-bit words in the attached data memory; used for the range check.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  zero-extend load result (LBU/LHU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  access faulted; valid only with resp_valid
- mem_addr  out  32  word index, equal to captured addr >> 2
- mem_wdata  out  32  write word
- mem_we  out  1  write strobe
- mem_rdata  in  32  combinational read data for mem_addr

Behaviour:
- Reset:
  - State goes to IDLE.
  - req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_we=0; mem_addr=0; mem_wdata=0.
  - mem_we is combinationally gated by reset_n, so no write occurs during any reset cycle, including reset asserted mid-RMW.
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture addr, size, we, unsigned and wdata, then go to ACCESS.
  - req_ready is 0 in every other state. No queueing.
- Error check at capture:
  - Error if size==11.
  - Error if half with addr[0]!=0.
  - Error if word with addr[1:0]!=0.
  - Error if addr[31:2] >= DEPTH.
  - On error, ACCESS performs no memory access (mem_we=0) and goes to RESP with err=1 and rdata=0.
- ACCESS, load:
  - Drive mem_addr.
  - Extract the byte or half selected by addr[1:0] from mem_rdata, extend per unsigned, and register it. Go to RESP.
- ACCESS, word store: drive mem_addr, mem_wdata=wdata and mem_we=1, then go to RESP.
- ACCESS, sub-word store:
  - Drive mem_addr and read mem_rdata.
  - Register a merged word: the selected byte or half lane is replaced by wdata[7:0] or wdata[15:0], other lanes are kept. Go to WRITE.
- WRITE: drive mem_addr, mem_wdata=merged word and mem_we=1, then go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then go to IDLE. The next request can be accepted the following cycle.
- Latency, from the accept edge (cycle t):
  - loads, word stores and errors: resp_valid in cycle t+2.
  - sub-word stores: resp_valid in cycle t+3.
- resp_valid has no backpressure; the consumer must take it.
- mem_addr holds its last value when idle. mem_we=0 outside ACCESS and WRITE.
- Lane rules:
  - Byte lane = addr[1:0]: lane 0 is bits 7:0, lane 3 is bits 31:24 (little-endian).
  - Half lane = addr[1]: lane 0 is bits 15:0, lane 1 is bits 31:16.

Optional Feature:
- LSU_BYTE_WRITE_EN defined:
  - Adds output mem_be[3:0] (byte-enables).
  - Sub-word stores skip the RMW read. ACCESS drives the replicated store data, the lane mask on mem_be and mem_we=1, then goes to RESP, so latency is t+2.
  - Word stores drive mem_be=1111. Loads and idle drive mem_be=0000.
  - WRITE state is unreachable.
- Undefined: no mem_be port; RMW behaviour as specified above.

Decomposition:
- Package lsu_pkg:
  - size_e enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD).
  - lsu_state_e enum.
  - Function or constant for the misalignment check.
- Sub-module lsu_lane_align, purely combinational:
  - load extract/extend: inputs rdata, addr[1:0], size, unsigned.
  - store merge: inputs old word, wdata, addr[1:0], size. Outputs the merged word and the byte mask.

Test Plan:
- Preload mem[5]=0x80FF7F01. Issue LB at addr 0x17 -> resp_rdata=0xFFFFFF80 at t+2. Issue LBU at addr 0x17 -> 0x00000080 at t+2.
- With mem[5]=0x80FF7F01, LH at addr 0x16 -> 0xFFFF80FF. LHU at addr 0x14 -> 0x00007F01.
- SB wdata=0xAB at addr 0x15 over mem[5]=0x80FF7F01 -> exactly one mem_we pulse at t+2, mem[5]=0x80FFAB01, resp_valid at t+3.
  - With LSU_BYTE_WRITE_EN: mem_be=0010 at t+1 and resp_valid at t+2.
- SW at addr 0x0E, and LH at addr 0x03 -> resp_err=1 and rdata=0 at t+2, no mem_we, memory unchanged. Access to byte address 4*DEPTH -> resp_err=1.
- Back-to-back: SW 0x12345678 to addr 0x20 is accepted. req_ready stays low until RESP completes. A following LW of addr 0x20 returns 0x12345678.
- Assert reset_n=0 in the ACCESS cycle of an SH -> no mem_we, memory unchanged. Next cycle: req_ready=1, resp_valid=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and alignment helper for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WRITE  = 2'b10,
        RESP   = 2'b11
    } lsu_state_e;

    // A reserved size is treated as an alignment fault so one check covers both.
    function automatic logic align_fault(input size_e size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: align_fault = 1'b0;
            SZ_HALF: align_fault = addr_lo[0];
            SZ_WORD: align_fault = (addr_lo != 2'b00);
            default: align_fault = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - combinational load extract/extend and store lane merge
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  size_e       size,
    input  logic        is_unsigned,
    output logic [31:0] load_data,
    output logic [31:0] lane_data,
    output logic [31:0] merged,
    output logic [3:0]  mask
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] bit_mask;

    // Pick the addressed lane out of the read word and sign/zero extend it.
    always_comb begin
        case (addr_lo)
            2'd0:    sel_byte = rdata[7:0];
            2'd1:    sel_byte = rdata[15:8];
            2'd2:    sel_byte = rdata[23:16];
            default: sel_byte = rdata[31:24];
        endcase
        sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & sel_byte[7]}}, sel_byte};
            SZ_HALF: load_data = {{16{~is_unsigned & sel_half[15]}}, sel_half};
            default: load_data = rdata;
        endcase
    end

    // Replicate store data across lanes and build the lane mask; merge keeps unselected lanes.
    always_comb begin
        case (size)
            SZ_BYTE: begin
                lane_data = {4{wdata[7:0]}};
                mask      = 4'b0001 << addr_lo;
            end
            SZ_HALF: begin
                lane_data = {2{wdata[15:0]}};
                mask      = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                lane_data = wdata;
                mask      = 4'b1111;
            end
        endcase
        bit_mask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        merged   = (rdata & ~bit_mask) | (lane_data & bit_mask);
    end

endmodule

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - LSU initiator for word memory; LSU_BYTE_WRITE_EN adds mem_be
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
`ifdef LSU_BYTE_WRITE_EN
    output logic [3:0]  mem_be,
`endif
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] DEPTH_W = DEPTH;

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q, merged_q;
    size_e       size_q;
    logic        we_q, uns_q, err_q;
    logic        mem_we_raw;
    logic        accept, req_err;
    logic [31:0] load_data, lane_data, merged;
    logic [3:0]  lane_mask;

    assign accept  = (state_q == IDLE) && req_valid;
    assign req_err = align_fault(size_e'(req_size), req_addr[1:0]) ||
                     ({2'b00, req_addr[31:2]} >= DEPTH_W);

    lsu_lane_align u_align (
        .rdata       (mem_rdata),
        .wdata       (wdata_q),
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .load_data   (load_data),
        .lane_data   (lane_data),
        .merged      (merged),
        .mask        (lane_mask)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Request capture at accept, load result and merged word registered in ACCESS.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= SZ_BYTE;
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            merged_q <= '0;
        end else if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= size_e'(req_size);
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            err_q   <= req_err;
        end else if (state_q == ACCESS) begin
            rdata_q  <= (!we_q && !err_q) ? load_data : 32'h0;
            merged_q <= merged;
        end
    end

    // Next state: sub-word stores detour through WRITE unless byte enables exist.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (req_valid) state_d = ACCESS;
            ACCESS: begin
                state_d = RESP;
`ifndef LSU_BYTE_WRITE_EN
                if (we_q && !err_q && (lane_mask != 4'b1111)) state_d = WRITE;
`endif
            end
            WRITE:  state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // Outputs from state; the write strobe is gated by reset_n so reset never writes.
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_rdata = (state_q == RESP) ? rdata_q : 32'h0;
        resp_err   = (state_q == RESP) && err_q;
        mem_addr   = {2'b00, addr_q[31:2]};
        mem_wdata  = 32'h0;
        mem_we_raw = 1'b0;
`ifdef LSU_BYTE_WRITE_EN
        mem_be     = 4'b0000;
        if (state_q == ACCESS && we_q && !err_q) begin
            mem_we_raw = 1'b1;
            mem_wdata  = lane_data;
            mem_be     = lane_mask;
        end else if (state_q == WRITE) begin
            mem_we_raw = 1'b1;
            mem_wdata  = merged_q;
            mem_be     = 4'b1111;
        end
`else
        if (state_q == ACCESS && we_q && !err_q && (lane_mask == 4'b1111)) begin
            mem_we_raw = 1'b1;
            mem_wdata  = lane_data;
        end else if (state_q == WRITE) begin
            mem_we_raw = 1'b1;
            mem_wdata  = merged_q;
        end
`endif
        mem_we = mem_we_raw && reset_n;
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - self-checking bench for lsu_mem_master with reference memory model
module tb_lsu_mem_master;

    localparam int DEPTH = 1024;
    localparam int AW    = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef LSU_BYTE_WRITE_EN
    logic [3:0]  mem_be;
`endif

    logic [31:0] mem     [DEPTH];
    logic [31:0] exp_mem [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] got_rd;
    logic        got_err;
    logic [3:0]  be_at1;

    always #5 clk = ~clk;

    lsu_mem_master #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
`ifdef LSU_BYTE_WRITE_EN
        .mem_be       (mem_be),
`endif
        .mem_rdata    (mem_rdata)
    );

    assign mem_rdata = (mem_addr < DEPTH) ? mem[mem_addr[AW-1:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_we && mem_addr < DEPTH) begin
`ifdef LSU_BYTE_WRITE_EN
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr[AW-1:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
`else
            mem[mem_addr[AW-1:0]] <= mem_wdata;
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int size_bytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic ref_err(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd3) return 1'b1;
        if (addr % size_bytes(size) != 0) return 1'b1;
        return (addr / 4) >= DEPTH;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [1:0] size, input logic uns);
        int bits = 8 * size_bytes(size);
        logic [31:0] v;
        logic [31:0] low_mask;
        if (bits == 32) return word;
        low_mask = (32'h1 << bits) - 1;
        v = (word >> (8 * (addr % 4))) & low_mask;
        if (!uns && v[bits-1]) v = v | ~low_mask;
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [31:0] addr,
                                              input logic [1:0] size, input logic [31:0] wdata);
        int bits = 8 * size_bytes(size);
        int sh   = 8 * (addr % 4);
        logic [31:0] m;
        if (bits == 32) return wdata;
        m = ((32'h1 << bits) - 1) << sh;
        return (word & ~m) | ((wdata << sh) & m);
    endfunction

    task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat, lat, we_cnt, word;
        logic        busy_ok;
        e_err = ref_err(size, addr);
        word  = addr / 4;
        e_rd  = (!we && !e_err) ? ref_load(exp_mem[word], addr, size, uns) : 32'h0;
        e_lat = 2;
`ifndef LSU_BYTE_WRITE_EN
        if (we && !e_err && size != 2'd2) e_lat = 3;
`endif
        @(negedge clk);
        check({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; we_cnt = 0; busy_ok = 1'b1; be_at1 = 4'hx;
        got_rd = 32'hx; got_err = 1'bx;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
`ifdef LSU_BYTE_WRITE_EN
            if (c == 1) be_at1 = mem_be;
`endif
            if (mem_we) we_cnt++;
            if (resp_valid) begin
                lat = c; got_rd = resp_rdata; got_err = resp_err;
                break;
            end
            if (req_ready) busy_ok = 1'b0;
        end
        if (we && !e_err) exp_mem[word] = ref_store(exp_mem[word], addr, size, wdata);
        check({tag, ".latency"}, lat, e_lat);
        check({tag, ".rdata"}, got_rd, e_rd);
        check({tag, ".err"}, {31'b0, got_err}, {31'b0, e_err});
        check({tag, ".we_pulses"}, we_cnt, (we && !e_err) ? 1 : 0);
        check({tag, ".busy"}, {31'b0, busy_ok}, 32'd1);
        if (word < DEPTH) check({tag, ".mem"}, mem[word], exp_mem[word]);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom; exp_mem[i] = mem[i];
        end
        mem[5] = 32'h80FF7F01; exp_mem[5] = 32'h80FF7F01;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.req_ready", {31'b0, req_ready}, 32'd1);
        check("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.resp_err", {31'b0, resp_err}, 32'd0);
        check("rst.mem_we", {31'b0, mem_we}, 32'd0);
        check("rst.mem_addr", mem_addr, 32'd0);
        check("rst.mem_wdata", mem_wdata, 32'd0);
        reset_n = 1'b1;

        do_req("lb_17", 1'b0, 2'd0, 1'b0, 32'h17, 32'h0);
        check("lb_17.const", got_rd, 32'hFFFFFF80);
        do_req("lbu_17", 1'b0, 2'd0, 1'b1, 32'h17, 32'h0);
        check("lbu_17.const", got_rd, 32'h00000080);
        do_req("lh_16", 1'b0, 2'd1, 1'b0, 32'h16, 32'h0);
        check("lh_16.const", got_rd, 32'hFFFF80FF);
        do_req("lhu_14", 1'b0, 2'd1, 1'b1, 32'h14, 32'h0);
        check("lhu_14.const", got_rd, 32'h00007F01);
        do_req("sb_15", 1'b1, 2'd0, 1'b0, 32'h15, 32'hAB);
        check("sb_15.const", mem[5], 32'h80FFAB01);
`ifdef LSU_BYTE_WRITE_EN
        check("sb_15.be", {28'b0, be_at1}, 32'h2);
`endif
        do_req("sw_0e", 1'b1, 2'd2, 1'b0, 32'h0E, 32'hDEADBEEF);
        do_req("lh_03", 1'b0, 2'd1, 1'b0, 32'h03, 32'h0);
        do_req("lw_oor", 1'b0, 2'd2, 1'b0, 4 * DEPTH, 32'h0);
        check("lw_oor.errconst", {31'b0, got_err}, 32'd1);
        do_req("sb_oor", 1'b1, 2'd0, 1'b0, 4 * DEPTH + 1, 32'h55);
        do_req("rsvd", 1'b0, 2'd3, 1'b0, 32'h20, 32'h0);
        do_req("sw_20", 1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678);
        do_req("lw_20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        check("lw_20.const", got_rd, 32'h12345678);
        do_req("lw_last", 1'b0, 2'd2, 1'b0, 4 * DEPTH - 4, 32'h0);

        // Reset during the ACCESS cycle of a half store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_addr = 32'h22; req_wdata = 32'h0000BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0; reset_n = 1'b0;
        @(negedge clk);
        check("rstmid.we_access", {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        check("rstmid.req_ready", {31'b0, req_ready}, 32'd1);
        check("rstmid.resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rstmid.we_after", {31'b0, mem_we}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rstmid.mem", mem[8], exp_mem[8]);

        for (int i = 0; i < 40; i++) begin
            sz = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) sz = 2'd3;
            a = $urandom_range(0, 63);
            if ($urandom_range(0, 7) == 0) a = 4 * DEPTH + $urandom_range(0, 64);
            do_req($sformatf("rnd%0d", i), 1'($urandom), sz, 1'($urandom), a, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
